// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        DATA   = 2'd2,
        RETIRE = 2'd3
    } arb_state_e;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/arb_timeout.sv
// Wait-cycle counter for one memory access; flags expiry on the last allowed idle cycle.
module arb_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // TIMEOUT==0 disables expiry; LAST is then a don't-care.
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr)
            r_cnt <= '0;
        else if (i_en && !o_expired)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = (TIMEOUT != 0) && i_en && (r_cnt == LAST);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter: sequences fetch -> decode -> optional data access -> retire
// for a stalled RV32I core, with a sticky bus timeout flag and a stall-cycle counter.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          XLEN    = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter logic [XLEN-1:0] NOP = XLEN'(NOP_INSTR)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] core_pc,
    output logic [XLEN-1:0] core_instr,
    input  logic            core_memaccess,
    input  logic            core_memwrite,
    input  logic [XLEN-1:0] core_addr,
    input  logic [XLEN-1:0] core_wdata,
    output logic [XLEN-1:0] core_rdata,
    output logic            core_iwait,
    output logic            core_dwait,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            bus_err,
    output logic [31:0]     stall_cnt
);

    arb_state_e      r_state;
    arb_state_e      w_next;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_rdata;
    logic            r_bus_err;
    logic [31:0]     r_stall_cnt;
    logic            w_busy;
    logic            w_expired;

    assign w_busy = (r_state == FETCH) || (r_state == DATA);

    arb_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_clr     (w_next != r_state),
        .i_en      (w_busy && !mem_ready),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:   if (mem_ready || w_expired) w_next = DECODE;
            DECODE:  w_next = core_memaccess ? DATA : RETIRE;
            DATA:    if (mem_ready || w_expired) w_next = RETIRE;
            default: w_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FETCH;
            r_instr     <= NOP;
            r_rdata     <= '0;
            r_bus_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == FETCH) begin
                if (mem_ready)
                    r_instr <= mem_rdata;
                else if (w_expired)
                    r_instr <= NOP;
            end
            if (r_state == DATA) begin
                if (mem_ready && !core_memwrite)
                    r_rdata <= mem_rdata;
                else if (w_expired)
                    r_rdata <= '0;
            end
            if (w_expired)
                r_bus_err <= 1'b1;
            if (core_iwait || core_dwait)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    // Reset kills any in-flight request in the same cycle.
    assign mem_req    = !reset && w_busy;
    assign mem_we     = (r_state == DATA) && core_memwrite;
    assign mem_addr   = (r_state == DATA) ? core_addr : core_pc;
    assign mem_wdata  = core_wdata;

    assign core_iwait = reset || (r_state != RETIRE);
    assign core_dwait = reset || (r_state == DATA) || ((r_state == DECODE) && core_memaccess);
    assign core_instr = r_instr;
    assign core_rdata = r_rdata;
    assign bus_err    = r_bus_err;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench: acts as core and memory, predicts per-instruction results from the access rules.
module tb_unified_mem_arbiter;

    localparam int TO = 4;
    localparam logic [31:0] NOPV = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] core_pc, core_instr, core_addr, core_wdata, core_rdata;
    logic        core_memaccess, core_memwrite, core_iwait, core_dwait;
    logic        mem_req, mem_we, mem_ready, bus_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mem [256];
    logic [31:0] exp_rdata;
    logic [31:0] exp_stall;
    logic        exp_err;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.XLEN(32), .TIMEOUT(TO), .NOP(NOPV)) dut (
        .clk(clk), .reset(reset),
        .core_pc(core_pc), .core_instr(core_instr),
        .core_memaccess(core_memaccess), .core_memwrite(core_memwrite),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_iwait(core_iwait), .core_dwait(core_dwait),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_err(bus_err), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered at a negedge with the DUT in FETCH; returns at the negedge after RETIRE.
    task automatic run_instr(input logic [31:0] pc, input bit acc, input bit wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int df, input int dd);
        bit          f_to = (df >= TO);
        bit          d_to = (dd >= TO);
        int          fcyc = f_to ? TO : df + 1;
        int          dcyc = d_to ? TO : dd + 1;
        logic [31:0] e_instr = f_to ? NOPV : mem[pc[9:2]];
        core_pc = pc; core_memaccess = acc; core_memwrite = wr;
        core_addr = addr; core_wdata = wdata;
        for (int w = 0; w < fcyc; w++) begin
            #1;
            chk("fetch_req", {31'd0, mem_req}, 32'd1);
            chk("fetch_we", {31'd0, mem_we}, 32'd0);
            chk("fetch_addr", mem_addr, pc);
            chk("fetch_iwait", {31'd0, core_iwait}, 32'd1);
            mem_ready = !f_to && (w == df);
            mem_rdata = mem_ready ? mem[pc[9:2]] : $urandom;
            @(negedge clk);
        end
        if (f_to) exp_err = 1'b1;
        #1;
        chk("dec_req", {31'd0, mem_req}, 32'd0);
        chk("dec_iwait", {31'd0, core_iwait}, 32'd1);
        chk("dec_dwait", {31'd0, core_dwait}, {31'd0, acc});
        chk("dec_instr", core_instr, e_instr);
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        @(negedge clk);
        if (acc) begin
            for (int w = 0; w < dcyc; w++) begin
                #1;
                chk("data_req", {31'd0, mem_req}, 32'd1);
                chk("data_we", {31'd0, mem_we}, {31'd0, wr});
                chk("data_addr", mem_addr, addr);
                chk("data_wdata", mem_wdata, wdata);
                chk("data_dwait", {31'd0, core_dwait}, 32'd1);
                mem_ready = !d_to && (w == dd);
                mem_rdata = $urandom;
                if (mem_ready) begin
                    if (wr) mem[addr[9:2]] = wdata;
                    else    exp_rdata = mem_rdata;
                end
                @(negedge clk);
            end
            if (d_to) begin
                exp_err = 1'b1;
                exp_rdata = '0;
            end
        end
        exp_stall = exp_stall + 32'(fcyc + 1 + (acc ? dcyc : 0));
        #1;
        chk("ret_iwait", {31'd0, core_iwait}, 32'd0);
        chk("ret_dwait", {31'd0, core_dwait}, 32'd0);
        chk("ret_req", {31'd0, mem_req}, 32'd0);
        chk("ret_instr", core_instr, e_instr);
        chk("ret_rdata", core_rdata, exp_rdata);
        chk("ret_bus_err", {31'd0, bus_err}, {31'd0, exp_err});
        chk("ret_stall_cnt", stall_cnt, exp_stall);
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        @(negedge clk);
    endtask

    task automatic check_after_reset(input logic [31:0] pc);
        exp_rdata = '0; exp_stall = '0; exp_err = 1'b0;
        #1;
        chk("rst_req", {31'd0, mem_req}, 32'd1);
        chk("rst_addr", mem_addr, pc);
        chk("rst_instr", core_instr, NOPV);
        chk("rst_rdata", core_rdata, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    endtask

    task automatic rand_instr();
        logic [31:0] pc   = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        logic [31:0] addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        int df = ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(0, 2);
        int dd = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 3);
        run_instr(pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom, df, dd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = NOPV;
        reset = 1'b1; mem_ready = 1'b0; mem_rdata = '0;
        core_pc = '0; core_memaccess = 1'b0; core_memwrite = 1'b0;
        core_addr = '0; core_wdata = '0;
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_hold_req", {31'd0, mem_req}, 32'd0);
        chk("rst_hold_iwait", {31'd0, core_iwait}, 32'd1);
        chk("rst_hold_dwait", {31'd0, core_dwait}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        check_after_reset(32'h0);

        run_instr(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);
        run_instr(32'h4, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 0, 0);
        run_instr(32'h8, 1'b1, 1'b0, 32'h100, 32'h0, 0, 3);
        run_instr(32'hC, 1'b0, 1'b0, 32'h0, 32'h0, TO + 3, 0);
        run_instr(32'h10, 1'b1, 1'b0, 32'h40, 32'h0, 1, TO);
        for (int i = 0; i < 40; i++) rand_instr();

        // Reset during a data access: request must drop in the same cycle.
        core_pc = 32'h20; core_memaccess = 1'b1; core_memwrite = 1'b1;
        core_addr = 32'h80; core_wdata = 32'h1234_5678;
        mem_ready = 1'b1; mem_rdata = mem[8];
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_data_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_dwait", {31'd0, core_dwait}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        check_after_reset(32'h20);

        for (int i = 0; i < 10; i++) rand_instr();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
